// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//
// Stall/flush controller for the 5-stage MIPS pipeline. It sits in ID next to
// the forwarding unit and handles the hazards that a bypass cannot resolve:
//   * load-use         : one bubble into ID/EX, PC and IF/ID held
//   * taken branch/jump: IF/ID loaded with a NOP, PC redirected
//   * data-memory wait : whole pipe frozen until DMemAck_i, with a timeout
//                        that parks the controller in HALT
//
// Parameters
//   CNT_W        width of the saturating StallCount_o / FlushCount_o
//   MEM_TIMEOUT  consecutive frozen memory cycles tolerated before HALT
//                (1 .. 2^16-1)
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   start_i             leave IDLE and run the pipeline
//   IfIdRsAddr_i        rs of the instruction in ID
//   IfIdRtAddr_i        rt of the instruction in ID
//   IfIdUsesRt_i        ID instruction reads rt as a source
//   IdExMemRead_i       instruction in EX is a load
//   IdExRtAddr_i        destination (rt) of the load in EX
//   BranchTaken_i       branch in ID resolved taken
//   JumpTaken_i         jump in ID
//   DMemReq_i           MEM stage has an access this cycle
//   DMemAck_i           data memory completes the access this cycle
//   PcWrite_o           PC update enable
//   IfIdWrite_o         IF/ID register enable
//   IfIdFlush_o         IF/ID loads a NOP
//   IdExFlush_o         ID/EX loads a NOP (bubble)
//   PipeFreeze_o        hold ID/EX, EX/MEM, MEM/WB and PC
//   MemTimeout_o        sticky: a memory wait exceeded MEM_TIMEOUT
//   StallCount_o        cycles stalled (PcWrite_o=0) while RUN/MEM_WAIT
//   FlushCount_o        cycles with IfIdFlush_o asserted
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       IfIdRsAddr_i,
    input  logic [4:0]       IfIdRtAddr_i,
    input  logic             IfIdUsesRt_i,
    input  logic             IdExMemRead_i,
    input  logic [4:0]       IdExRtAddr_i,
    input  logic             BranchTaken_i,
    input  logic             JumpTaken_i,
    input  logic             DMemReq_i,
    input  logic             DMemAck_i,
    output logic             PcWrite_o,
    output logic             IfIdWrite_o,
    output logic             IfIdFlush_o,
    output logic             IdExFlush_o,
    output logic             PipeFreeze_o,
    output logic             MemTimeout_o,
    output logic [CNT_W-1:0] StallCount_o,
    output logic [CNT_W-1:0] FlushCount_o
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    localparam int unsigned WAIT_W = 16;

    // One bit wider than the wait counter so the "+1" compare cannot overflow.
    localparam logic [WAIT_W:0] TIMEOUT_LIM = (WAIT_W+1)'(MEM_TIMEOUT);

    // The first frozen cycle (in RUN) already counts as wait cycle 1, so a
    // timeout of 1 has expired by the time that cycle ends.
    localparam logic TIMEOUT_AT_ENTRY = (MEM_TIMEOUT <= 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q,       state_d;
    logic [WAIT_W-1:0]   wait_cnt_q,    wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q,   flush_cnt_d;

    // -------------------------------------------------------------------------
    // Hazard decode (pure function of state and inputs)
    // -------------------------------------------------------------------------
    logic            active;
    logic            mem_freeze;
    logic            load_use;
    logic            redirect;
    logic [WAIT_W:0] wait_next;
    logic            timeout_hit;

    assign active = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

    // Once waiting, the outstanding access keeps the pipe frozen until the
    // ack arrives, whatever DMemReq_i does in the meantime.
    assign mem_freeze = (state_q == ST_MEM_WAIT) ? ~DMemAck_i
                                                 : (DMemReq_i & ~DMemAck_i);

    // $zero is never a real producer, so a load into r0 is never a hazard.
    assign load_use = IdExMemRead_i
                    && (IdExRtAddr_i != 5'd0)
                    && ((IdExRtAddr_i == IfIdRsAddr_i)
                        || (IfIdUsesRt_i && (IdExRtAddr_i == IfIdRtAddr_i)));

    assign redirect = BranchTaken_i | JumpTaken_i;

    assign wait_next   = {1'b0, wait_cnt_q} + (WAIT_W+1)'(1);
    assign timeout_hit = (wait_next >= TIMEOUT_LIM);

    // -------------------------------------------------------------------------
    // Pipeline control outputs
    // -------------------------------------------------------------------------
    // NOTE: every output gets a value before any branch; a path that skipped
    // one would leave it holding its old value and infer a latch.
    always_comb begin
        PcWrite_o    = 1'b0;
        IfIdWrite_o  = 1'b0;
        IfIdFlush_o  = 1'b0;
        IdExFlush_o  = 1'b0;
        PipeFreeze_o = 1'b1;

        if (active) begin
            PcWrite_o    = 1'b1;
            IfIdWrite_o  = 1'b1;
            PipeFreeze_o = 1'b0;

            if (mem_freeze) begin
                PcWrite_o    = 1'b0;
                IfIdWrite_o  = 1'b0;
                PipeFreeze_o = 1'b1;
            end else if (load_use) begin
                // A branch/jump seen now is ignored: the same instruction is
                // still in ID next cycle and is re-evaluated then.
                PcWrite_o    = 1'b0;
                IfIdWrite_o  = 1'b0;
                IdExFlush_o  = 1'b1;
            end else if (redirect) begin
                IfIdFlush_o  = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_freeze) begin
                    if (TIMEOUT_AT_ENTRY) begin
                        state_d       = ST_HALT;
                        mem_timeout_d = 1'b1;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (DMemAck_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (timeout_hit) begin
                    state_d       = ST_HALT;
                    wait_cnt_d    = '0;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_next[WAIT_W-1:0];
                end
            end

            ST_HALT: begin
                wait_cnt_d = '0;
            end

            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Saturating event counters
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // PcWrite_o is also low in IDLE/HALT, which must not count.
        if (active && !PcWrite_o && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (IfIdFlush_o && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign MemTimeout_o = mem_timeout_q;
    assign StallCount_o = stall_cnt_q;
    assign FlushCount_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Two instances share one stimulus stream: A uses the default parameters,
// B uses CNT_W=2 / MEM_TIMEOUT=4 so saturation and timeout are reached
// quickly. Each instance is compared every cycle against a rule-level model.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int unsigned A_CNT_W = 16;
    localparam int unsigned A_TMO   = 255;
    localparam int unsigned B_CNT_W = 2;
    localparam int unsigned B_TMO   = 4;
    localparam int          A_MAX   = (1 << A_CNT_W) - 1;
    localparam int          B_MAX   = (1 << B_CNT_W) - 1;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_i, start_i, uses_rt, mem_read, br, jmp, req, ack;
    logic [4:0] rs, rt, ex_rt;

    logic               a_pc, a_ifw, a_iff, a_idf, a_frz, a_tmo;
    logic [A_CNT_W-1:0] a_sc, a_fc;
    logic               b_pc, b_ifw, b_iff, b_idf, b_frz, b_tmo;
    logic [B_CNT_W-1:0] b_sc, b_fc;

    hazard_stall_unit #(.CNT_W(A_CNT_W), .MEM_TIMEOUT(A_TMO)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .IfIdRsAddr_i(rs), .IfIdRtAddr_i(rt), .IfIdUsesRt_i(uses_rt),
        .IdExMemRead_i(mem_read), .IdExRtAddr_i(ex_rt),
        .BranchTaken_i(br), .JumpTaken_i(jmp),
        .DMemReq_i(req), .DMemAck_i(ack),
        .PcWrite_o(a_pc), .IfIdWrite_o(a_ifw), .IfIdFlush_o(a_iff),
        .IdExFlush_o(a_idf), .PipeFreeze_o(a_frz), .MemTimeout_o(a_tmo),
        .StallCount_o(a_sc), .FlushCount_o(a_fc)
    );

    hazard_stall_unit #(.CNT_W(B_CNT_W), .MEM_TIMEOUT(B_TMO)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .IfIdRsAddr_i(rs), .IfIdRtAddr_i(rt), .IfIdUsesRt_i(uses_rt),
        .IdExMemRead_i(mem_read), .IdExRtAddr_i(ex_rt),
        .BranchTaken_i(br), .JumpTaken_i(jmp),
        .DMemReq_i(req), .DMemAck_i(ack),
        .PcWrite_o(b_pc), .IfIdWrite_o(b_ifw), .IfIdFlush_o(b_iff),
        .IdExFlush_o(b_idf), .PipeFreeze_o(b_frz), .MemTimeout_o(b_tmo),
        .StallCount_o(b_sc), .FlushCount_o(b_fc)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: "started", "halted", length of the current frozen
    // memory streak, and plain integer counters clamped at their maximum.
    // -------------------------------------------------------------------------
    typedef struct {
        bit run;
        bit halt;
        int streak;
        int stalls;
        int flushes;
        bit tmo;
    } mdl_t;

    localparam mdl_t M0 = '{run: 0, halt: 0, streak: 0, stalls: 0, flushes: 0, tmo: 0};

    mdl_t ma, mb;

    // Control vector order: {PcWrite, IfIdWrite, IfIdFlush, IdExFlush, PipeFreeze}
    function automatic logic [4:0] predict(mdl_t m);
        bit mem_stall, lu;
        if (!m.run || m.halt) return 5'b00001;
        mem_stall = (m.streak > 0) ? !ack : (req && !ack);
        lu = mem_read && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
        if (mem_stall)   return 5'b00001;
        if (lu)          return 5'b00010;
        if (br || jmp)   return 5'b11100;
        return 5'b11000;
    endfunction

    function automatic mdl_t advance(mdl_t m, int tmo_lim, int cnt_max);
        logic [4:0] o;
        mdl_t n = m;
        if (!m.run) begin
            n.run = start_i;
            return n;
        end
        if (m.halt) return n;
        o = predict(m);
        if (!o[4]) n.stalls  = (m.stalls  < cnt_max) ? m.stalls  + 1 : cnt_max;
        if (o[2])  n.flushes = (m.flushes < cnt_max) ? m.flushes + 1 : cnt_max;
        if (o[0]) begin
            n.streak = m.streak + 1;
            if (n.streak >= tmo_lim) begin
                n.halt   = 1;
                n.tmo    = 1;
                n.streak = 0;
            end
        end else begin
            n.streak = 0;
        end
        return n;
    endfunction

    task automatic check_one(input string nm, input logic [4:0] ctl, input logic tmo,
                             input int sc, input int fc, input mdl_t m);
        check({nm, ".ctl"},   32'(ctl), 32'(predict(m)));
        check({nm, ".tmo"},   32'(tmo), 32'(m.tmo));
        check({nm, ".stall"}, sc,       m.stalls);
        check({nm, ".flush"}, fc,       m.flushes);
    endtask

    task automatic check_both();
        check_one("A", {a_pc, a_ifw, a_iff, a_idf, a_frz}, a_tmo, int'(a_sc), int'(a_fc), ma);
        check_one("B", {b_pc, b_ifw, b_iff, b_idf, b_frz}, b_tmo, int'(b_sc), int'(b_fc), mb);
    endtask

    // One clock: compare mid-cycle, advance the model on the same inputs the
    // DUT will sample, then return just after the edge.
    task automatic step();
        @(negedge clk_i);
        check_both();
        ma = advance(ma, A_TMO, A_MAX);
        mb = advance(mb, B_TMO, B_MAX);
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        start_i = 0; uses_rt = 0; mem_read = 0; br = 0; jmp = 0;
        req = 0; ack = 0; rs = 0; rt = 0; ex_rt = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst_i = 1;
        #1;
        ma = M0;
        mb = M0;
        check_both();
        rst_i = 0;
        #1;
    endtask

    int ack_pct;

    initial begin
        clear_inputs();
        rst_i = 1;
        ma = M0;
        mb = M0;
        @(posedge clk_i);
        #1;
        do_reset();
        check("reset_freeze", 32'(a_frz), 32'd1);
        check("reset_stall", 32'(a_sc), 32'd0);

        // IDLE holds until start_i; the start cycle itself is still frozen.
        step();
        start_i = 1;
        step();
        start_i = 0;
        #1;
        check("run_pcwrite", 32'(a_pc), 32'd1);
        step();

        // lw $5 in EX, ID reads rs=5: exactly one bubble.
        mem_read = 1; ex_rt = 5; rs = 5;
        #1;
        check("lu_pcwrite", 32'(a_pc), 32'd0);
        check("lu_bubble", 32'(a_idf), 32'd1);
        step();
        clear_inputs();
        #1;
        check("lu_after", 32'(a_pc), 32'd1);
        check("lu_count", 32'(a_sc), 32'd1);
        step();

        // rt match only matters when the ID instruction reads rt.
        mem_read = 1; ex_rt = 5; rs = 3; rt = 5; uses_rt = 0;
        #1;
        check("rt_unused", 32'(a_pc), 32'd1);
        step();
        uses_rt = 1;
        step();
        // Load into $zero never stalls.
        ex_rt = 0; rs = 0; rt = 0;
        #1;
        check("r0_no_stall", 32'(a_pc), 32'd1);
        step();

        // Memory access acknowledged after three frozen cycles.
        clear_inputs();
        req = 1;
        repeat (3) step();
        ack = 1;
        #1;
        check("mem_unfreeze", 32'(a_frz), 32'd0);
        check("mem_stall_count", 32'(a_sc), 32'd5);
        check("b_saturated", 32'(b_sc), 32'd3);
        step();
        clear_inputs();

        // Load-use masks a same-cycle branch; the branch flushes next cycle.
        mem_read = 1; ex_rt = 5; rs = 5; br = 1;
        #1;
        check("lu_masks_branch", 32'(a_iff), 32'd0);
        step();
        mem_read = 0;
        #1;
        check("branch_flush", 32'(a_iff), 32'd1);
        step();
        check("flush_count", 32'(a_fc), 32'd1);
        clear_inputs();

        // No ack: B (timeout 4) halts after four frozen cycles, A keeps waiting.
        req = 1;
        repeat (4) step();
        check("b_timeout", 32'(b_tmo), 32'd1);
        check("a_still_wait", 32'(a_tmo), 32'd0);
        req = 0; ack = 1; start_i = 1;
        repeat (2) step();
        check("b_sticky", 32'(b_tmo), 32'd1);
        check("b_halt_frozen", 32'(b_pc), 32'd0);
        clear_inputs();
        req = 1;
        step();
        do_reset();
        check("rst_a_idle", 32'(a_frz), 32'd1);
        check("rst_b_tmo", 32'(b_tmo), 32'd0);
        check("rst_stall", 32'(a_sc), 32'd0);

        // Randomized phase.
        ack_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(199) == 0) do_reset();
            if ((i % 64) == 0) ack_pct = int'($urandom_range(60));
            start_i  = ($urandom_range(7) == 0);
            rs       = 5'($urandom_range(3));
            rt       = 5'($urandom_range(3));
            ex_rt    = 5'($urandom_range(3));
            uses_rt  = $urandom_range(1) == 1;
            mem_read = ($urandom_range(2) == 0);
            br       = ($urandom_range(5) == 0);
            jmp      = ($urandom_range(9) == 0);
            req      = ($urandom_range(4) == 0);
            ack      = (int'($urandom_range(99)) < ack_pct);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
